// File: rtl/writeback_stage_pkg.sv
// Shared types and sizes for the writeback stage and its forwarding lookup.
package writeback_stage_pkg;
   localparam int REG_AW           = 6;
   localparam int REG_DW           = 16;
   localparam int WB_DEPTH_DEFAULT = 4;

   typedef struct packed {
      logic [REG_AW-1:0] addr;
      logic [REG_DW-1:0] data;
   } wb_entry_t;
endpackage

// File: rtl/wb_fwd_lookup.sv
// Youngest-match search of pending writes for one read address.
// Only built when WB_FORWARD_EN is defined.
`ifdef WB_FORWARD_EN
module wb_fwd_lookup
   import writeback_stage_pkg::*;
#(
   parameter int DEPTH = WB_DEPTH_DEFAULT,
   parameter int PW    = $clog2(DEPTH),
   parameter int CW    = PW + 1
) (
   input  wb_entry_t [DEPTH-1:0] entries,
   input  logic [PW-1:0]         head,
   input  logic [CW-1:0]         count,
   input  wb_entry_t             port1,
   input  logic                  port1_en,
   input  wb_entry_t             port2,
   input  logic                  port2_en,
   input  logic [REG_AW-1:0]     rd_addr,
   output logic                  hit,
   output logic [REG_DW-1:0]     data
);
   logic [PW-1:0] idx;

   // Walk oldest to youngest so the last match (the youngest) wins.
   always_comb begin
      hit  = 1'b0;
      data = '0;
      idx  = '0;
      if (port1_en && port1.addr == rd_addr) begin
         hit  = 1'b1;
         data = port1.data;
      end
      if (port2_en && port2.addr == rd_addr) begin
         hit  = 1'b1;
         data = port2.data;
      end
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + PW'(i);
         if (CW'(i) < count && entries[idx].addr == rd_addr) begin
            hit  = 1'b1;
            data = entries[idx].data;
         end
      end
   end
endmodule
`endif

// File: rtl/writeback_stage.sv
// Final pipeline stage: in-order result queue draining into two register-file write ports.
// Define WB_FORWARD_EN to build the pending-write forwarding lookups.
module writeback_stage
   import writeback_stage_pkg::*;
#(
   parameter int DEPTH = WB_DEPTH_DEFAULT,
   parameter int AW    = REG_AW,
   parameter int DW    = REG_DW
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          ex_valid,
   output logic          ex_ready,
   input  logic [AW-1:0] ex_addr,
   input  logic [DW-1:0] ex_data,
   input  logic          mem_valid,
   output logic          mem_ready,
   input  logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_data,
   output logic [AW-1:0] reg_wr1,
   output logic [DW-1:0] reg_wr1_data,
   output logic          reg_wr1_enable,
   output logic [AW-1:0] reg_wr2,
   output logic [DW-1:0] reg_wr2_data,
   output logic          reg_wr2_enable,
   input  logic [AW-1:0] fwd_rd1,
   input  logic [AW-1:0] fwd_rd2,
   input  logic [AW-1:0] fwd_rd3,
   output logic          fwd_hit1,
   output logic          fwd_hit2,
   output logic          fwd_hit3,
   output logic [DW-1:0] fwd_data1,
   output logic [DW-1:0] fwd_data2,
   output logic [DW-1:0] fwd_data3
);
   localparam int            PW      = $clog2(DEPTH);
   localparam int            CW      = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] TWO_C   = CW'(2);

   wb_entry_t     queue_reg [DEPTH];
   logic [PW-1:0] head_reg, tail_reg;
   logic [CW-1:0] count_reg;
   wb_entry_t     port1_reg, port2_reg;
   logic          en1_reg, en2_reg;

   logic          ex_push, mem_push;
   logic [CW-1:0] pop_cnt, push_cnt, count_next;
   logic [PW-1:0] mem_slot;

   // Readiness looks only at the occupancy before this cycle's pops.
   assign ex_ready   = count_reg < DEPTH_C;
   assign mem_ready  = count_reg <= (DEPTH_C - TWO_C);
   assign ex_push    = ex_valid & ex_ready;
   assign mem_push   = mem_valid & mem_ready;
   assign pop_cnt    = (count_reg >= TWO_C) ? TWO_C : count_reg;
   assign push_cnt   = CW'(ex_push) + CW'(mem_push);
   assign count_next = count_reg + push_cnt - pop_cnt;
   assign mem_slot   = ex_push ? tail_reg + PW'(1) : tail_reg;

   always_ff @(posedge clock) begin
      if (ex_push)
         queue_reg[tail_reg] <= '{addr: ex_addr, data: ex_data};
      if (mem_push)
         queue_reg[mem_slot] <= '{addr: mem_addr, data: mem_data};
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
         port1_reg <= '0;
         port2_reg <= '0;
         en1_reg   <= 1'b0;
         en2_reg   <= 1'b0;
      end else begin
         head_reg  <= head_reg + pop_cnt[PW-1:0];
         tail_reg  <= tail_reg + push_cnt[PW-1:0];
         count_reg <= count_next;
         en1_reg   <= (pop_cnt != '0);
         en2_reg   <= (pop_cnt == TWO_C);
         if (pop_cnt != '0)
            port1_reg <= queue_reg[head_reg];
         if (pop_cnt == TWO_C)
            port2_reg <= queue_reg[head_reg + PW'(1)];
      end
   end

   assign reg_wr1        = port1_reg.addr;
   assign reg_wr1_data   = port1_reg.data;
   assign reg_wr1_enable = en1_reg;
   assign reg_wr2        = port2_reg.addr;
   assign reg_wr2_data   = port2_reg.data;
   assign reg_wr2_enable = en2_reg;

`ifdef WB_FORWARD_EN
   wb_entry_t [DEPTH-1:0] entries_flat;
   logic [AW-1:0]         fwd_rd   [3];
   logic [2:0]            fwd_hit;
   logic [DW-1:0]         fwd_data [3];

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_flat
         assign entries_flat[gi] = queue_reg[gi];
      end
   endgenerate

   assign fwd_rd[0] = fwd_rd1;
   assign fwd_rd[1] = fwd_rd2;
   assign fwd_rd[2] = fwd_rd3;

   generate
      for (gi = 0; gi < 3; gi++) begin : g_lookup
         wb_fwd_lookup #(.DEPTH(DEPTH), .PW(PW), .CW(CW)) u_lookup (
            .entries  (entries_flat),
            .head     (head_reg),
            .count    (count_reg),
            .port1    (port1_reg),
            .port1_en (en1_reg),
            .port2    (port2_reg),
            .port2_en (en2_reg),
            .rd_addr  (fwd_rd[gi]),
            .hit      (fwd_hit[gi]),
            .data     (fwd_data[gi])
         );
      end
   endgenerate

   assign fwd_hit1  = fwd_hit[0];
   assign fwd_hit2  = fwd_hit[1];
   assign fwd_hit3  = fwd_hit[2];
   assign fwd_data1 = fwd_data[0];
   assign fwd_data2 = fwd_data[1];
   assign fwd_data3 = fwd_data[2];
`else
   logic unused_fwd_rd;
   assign unused_fwd_rd = ^{fwd_rd1, fwd_rd2, fwd_rd3};
   assign fwd_hit1  = 1'b0;
   assign fwd_hit2  = 1'b0;
   assign fwd_hit3  = 1'b0;
   assign fwd_data1 = '0;
   assign fwd_data2 = '0;
   assign fwd_data3 = '0;
`endif
endmodule
